clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable, parametrised clock divider for the CPU31 clocking path. It generates a divided clock-level signal `clk_out` and a single-cycle `tick` strobe from the board clock. The divide ratio can be changed at run time without glitches. It replaces fixed power-of-two division wherever a peripheral or the CPU core needs an arbitrary, software-chosen rate.

## Interface
- `WIDTH`, 16: width of the counter, divisor and duty fields.
- `DEFAULT_DIV`, 8: divisor in effect after reset; must be ≥ 2 and < 2^WIDTH.

Ports:
- `clk_in`  input  1  sole clock; all logic on its rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `en`  input  1  count enable; when 0, all state holds.
- `load`  input  1  single-cycle request to capture `div_in` and `duty_in`.
- `div_in`  input  WIDTH  requested divisor D.
- `duty_in`  input  WIDTH  requested high-time H in cycles; used only with `CLK_DIV_DUTY_EN`.
- `clk_out`  output  1  registered divided clock; period D cycles.
- `tick`  output  1  registered one-cycle pulse; coincides with each rising edge of `clk_out`.
- `pending`  output  1  a loaded setting is waiting for the next period boundary.
- `cnt`  output  WIDTH  current phase counter, 0..D-1.

## Operation
- Effective registers: `d_cur` and `h_cur`. Pending registers: `d_pend` and `h_pend`.
- Reset values: `cnt` = DEFAULT_DIV-1, `d_cur` = DEFAULT_DIV, `h_cur` = DEFAULT_DIV>>1, `clk_out` = 0, `tick` = 0, `pending` = 0.
- Wrap condition: `en`=1 and `cnt` == `d_cur`-1.
- Each enabled cycle, the next count is 0 on wrap, otherwise `cnt`+1.
- `tick` is registered: 1 when the next count is 0, else 0.
- `clk_out` is registered: 1 when the next count < `h_cur` (using the updated `h_cur` on wrap), else 0.
- With `en`=0: `cnt` and `clk_out` hold, `tick` = 0, and no new setting is applied. `load` is still captured.
- Load capture: `load`=1 writes `d_pend` = max(`div_in`, 2) and `h_pend`, and sets `pending`=1. A second load before apply overwrites the first (last wins).
- Apply: on wrap with `pending`=1, `d_pend`/`h_pend` move to `d_cur`/`h_cur` and `pending` clears. The new period starts at `cnt`=0.
- `load` coincident with a wrap edge:
  - the wrap applies the old pending contents, if any;
  - the new values land in the pending registers with `pending`=1;
  - they apply at the following wrap.
- Divisor arithmetic is unsigned WIDTH bits. Values 0 and 1 are clamped to 2, so maximum D = 2^WIDTH-1. D-1 never underflows.

## Timing
- After `rst` is released with `en`=1:
  - the first enabled edge produces `tick`=1 and `clk_out`=1;
  - the rising edges of `clk_out` repeat every D cycles.
- `clk_out` is high for H consecutive cycles and low for D-H cycles. It changes only on `clk_in` edges and never glitches.
- Load-to-effect latency: the remainder of the current period, i.e. (`d_cur`-1-`cnt`) enabled cycles plus the wrap edge. The first period at the new rate begins with that `tick`.
- `rst` asserted mid-period: on the next edge, all registers return to their reset values and the pending setting is discarded. `rst` has priority over `en` and `load`.

## Configuration
- `CLK_DIV_DUTY_EN` defined:
  - `h_pend` = `duty_in` clamped to [1, D_req-1], where D_req is the clamped divisor loaded in the same cycle.
  - This gives arbitrary duty cycles.
- `CLK_DIV_DUTY_EN` undefined:
  - `duty_in` is ignored and `h_pend` registers are not built;
  - H is always `d_cur`>>1, computed from the divisor in effect;
  - odd D gives a shorter high phase (D=5: 2 high, 3 low).

## Test plan
- Reset, then `en`=1, no load → `tick` at cycles 1, 9, 17; `clk_out` high in cycles 1-4, low in cycles 5-8; `cnt` sequence 0..7.
- `load` with D=5 at cycle 3 → `pending`=1 until cycle 9; next ticks at 9 and 14; `clk_out` high for 2 cycles and low for 3.
- `load` with D=0, then `load` with D=1 → both clamp to 2; `clk_out` toggles every cycle and `tick` occurs every 2 cycles. A second load before the wrap overwrites the first.
- `en`=0 for 4 cycles mid-period → `cnt` and `clk_out` are frozen and `tick` stays 0; the period resumes and is lengthened by exactly 4 cycles.
- `rst` pulse mid-period with a load pending → outputs go to their reset values on the next edge; D = 8 again and `pending`=0.
- With `CLK_DIV_DUTY_EN`:
  - D=10, duty=3 → 3 cycles high, 7 low;
  - duty=0 → 1 high;
  - duty=12 → 9 high.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle for the programmable clock divider.
interface clk_div_prog_if #(parameter int WIDTH = 16);
   logic en, load, clk_out, tick, pending;
   logic [WIDTH-1:0] div_in, duty_in, cnt;
   modport master (output en, load, div_in, duty_in, input clk_out, tick, pending, cnt);
   modport slave (input en, load, div_in, duty_in, output clk_out, tick, pending, cnt);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable glitch-free clock divider with double-buffered divisor.
// Define CLK_DIV_DUTY_EN to allow a programmable high time instead of the fixed D>>1.
module clk_div_prog #(
   parameter int WIDTH = 16,
   parameter int DEFAULT_DIV = 8
) (
   input logic clk_in,
   input logic rst,
   clk_div_prog_if.slave bus
);
   localparam logic [WIDTH-1:0] DDIV = WIDTH'(DEFAULT_DIV);
   logic [WIDTH-1:0] cnt, d_cur, d_pend, d_req, d_nxt, h_nxt, cnt_nxt;
   logic clk_out, tick, pending, wrap, apply;
   assign wrap = bus.en && cnt == d_cur - 1'b1;
   assign apply = wrap && pending;
   assign d_req = bus.div_in < WIDTH'(2) ? WIDTH'(2) : bus.div_in;
   assign d_nxt = apply ? d_pend : d_cur;
   assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
`ifdef CLK_DIV_DUTY_EN
   logic [WIDTH-1:0] h_cur, h_pend, h_req;
   assign h_req = bus.duty_in == '0 ? WIDTH'(1) : bus.duty_in > d_req - 1'b1 ? d_req - 1'b1 : bus.duty_in;
   assign h_nxt = apply ? h_pend : h_cur;
   always_ff @(posedge clk_in) begin
      if (rst) begin
         h_cur <= DDIV >> 1;
         h_pend <= DDIV >> 1;
      end else begin
         if (bus.load) h_pend <= h_req;
         if (bus.en) h_cur <= h_nxt;
      end
   end
`else
   logic unused_duty;
   assign unused_duty = ^bus.duty_in;
   assign h_nxt = d_nxt >> 1;
`endif
   // A load on the wrap edge lands in the pending slot after the old contents are applied.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt <= DDIV - 1'b1;
         d_cur <= DDIV;
         d_pend <= DDIV;
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick <= 1'b0;
      end else begin
         if (bus.load) begin
            d_pend <= d_req;
            pending <= 1'b1;
         end else if (apply) pending <= 1'b0;
         if (bus.en) begin
            cnt <= cnt_nxt;
            d_cur <= d_nxt;
            tick <= cnt_nxt == '0;
            clk_out <= cnt_nxt < h_nxt;
         end else tick <= 1'b0;
      end
   end
   assign bus.cnt = cnt;
   assign bus.tick = tick;
   assign bus.clk_out = clk_out;
   assign bus.pending = pending;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed scoreboard bench for clk_div_prog against a cycle model.
module tb_clk_div_prog;
`ifdef CLK_DIV_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif
   typedef struct {logic tick, clk_out, pending; logic [15:0] cnt;} exp_t;
   logic clk = 1'b0, rst = 1'b1;
   int errors = 0, checks = 0, cyc = 0, highs = 0;
   exp_t q[$];
   logic [15:0] m_cnt, m_d, m_h, m_dp, m_hp;
   logic m_pend, m_clk, m_tick;
   clk_div_prog_if #(.WIDTH(16)) bus ();
   clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(8)) dut (.clk_in(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask
   task automatic step(input logic r, input logic e, input logic l, input logic [15:0] d, input logic [15:0] h);
      exp_t x;
      rst = r; bus.en = e; bus.load = l; bus.div_in = d; bus.duty_in = h;
      if (r) begin
         m_cnt = 7; m_d = 8; m_h = 4; m_dp = 8; m_hp = 4; m_pend = 0; m_clk = 0; m_tick = 0;
      end else begin
         if (e) begin
            if (m_cnt == m_d - 1) begin
               m_cnt = 0;
               if (m_pend) begin m_d = m_dp; m_h = m_hp; m_pend = 0; end
            end else m_cnt++;
            m_tick = m_cnt == 0;
            m_clk = m_cnt < (DUTY ? m_h : m_d / 2);
         end else m_tick = 0;
         if (l) begin
            m_dp = d < 2 ? 16'd2 : d;
            m_hp = h < 1 ? 16'd1 : (h >= m_dp ? m_dp - 1 : h);
            m_pend = 1;
         end
      end
      q.push_back('{m_tick, m_clk, m_pend, m_cnt});
      @(posedge clk);
      #1;
      cyc = r ? 0 : cyc + 1;
      x = q.pop_front();
      chk("tick", bus.tick, x.tick);
      chk("clk_out", bus.clk_out, x.clk_out);
      chk("pending", bus.pending, x.pending);
      chk("cnt", bus.cnt, x.cnt);
   endtask
   initial begin
      bus.en = 0; bus.load = 0; bus.div_in = 0; bus.duty_in = 0;
      step(1, 0, 0, 0, 0);
      chk("rst_cnt", bus.cnt, 7);
      chk("rst_clk", bus.clk_out, 0);
      chk("rst_tick", bus.tick, 0);
      chk("rst_pend", bus.pending, 0);
      // free run at the default divisor of 8
      for (int i = 1; i <= 17; i++) begin
         step(0, 1, 0, 0, 0);
         if (i == 1 || i == 9 || i == 17) chk("def_tick", bus.tick, 1);
         if (i == 4) chk("def_hi", bus.clk_out, 1);
         if (i == 5) chk("def_lo", bus.clk_out, 0);
      end
      // divisor 5 loaded at cycle 3
      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         step(0, 1, i == 3, 5, 0);
         if (i == 8) chk("d5_pend", bus.pending, 1);
         if (i == 9) chk("d5_apply", {bus.pending, bus.tick}, 2'b01);
         if (i == 10) chk("d5_hi", bus.clk_out, 1);
         if (i == 11) chk("d5_lo", bus.clk_out, 0);
         if (i == 14) chk("d5_tick", bus.tick, 1);
      end
      // clamp of 0 and 1, then last-wins overwrite
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 6, 0);
      step(0, 1, 1, 3, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
      // enable gap of four cycles mid-period
      step(0, 1, 1, 9, 0);
      for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
      // reset with a load pending
      step(0, 1, 1, 3, 0);
      step(0, 1, 0, 0, 0);
      step(1, 1, 1, 4, 0);
      chk("mid_rst_cnt", bus.cnt, 7);
      chk("mid_rst_pend", bus.pending, 0);
      for (int i = 1; i <= 9; i++) begin
         step(0, 1, 0, 0, 0);
         if (i == 9) chk("post_rst_tick", bus.tick, 1);
      end
`ifdef CLK_DIV_DUTY_EN
      for (int t = 0; t < 3; t++) begin
         step(1, 0, 0, 0, 0);
         step(0, 1, 1, 10, t == 0 ? 16'd3 : (t == 1 ? 16'd0 : 16'd12));
         for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
         highs = 0;
         for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0);
            highs += int'(bus.clk_out);
         end
         chk("duty_highs", highs, t == 0 ? 3 : (t == 1 ? 1 : 9));
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
